// File: rtl/hack_pkg.sv
// rtl/hack_pkg.sv - shared state, halt-cause and PC width definitions for the Hack ROM loader
package hack_pkg;

   localparam int HACK_PC_W = 15;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_LOAD = 2'd1;
   localparam state_t ST_RUN  = 2'd2;
   localparam state_t ST_HALT = 2'd3;

   typedef enum logic [1:0] {
      HALT_NONE    = 2'd0,
      HALT_LOOP    = 2'd1,
      HALT_TIMEOUT = 2'd2
   } halt_cause_t;

endpackage

// File: rtl/hack_rom_mem.sv
// rtl/hack_rom_mem.sv - program array, one synchronous write port and one asynchronous read port
module hack_rom_mem #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   // Contents survive reset so a program can be re-run after a warm reset of the CPU side.
   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - streamed program load, instruction fetch and run/halt control for the Hack CPU
import hack_pkg::*;

module hack_rom_loader #(
   parameter int              ADDR_W       = 8,
   parameter int              DATA_W       = 16,
   parameter int              CNT_W        = 32,
   parameter longint unsigned MAX_CYCLES   = 1000,
   parameter int              STALL_CYCLES = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_valid,
   input  logic [DATA_W-1:0]    load_data,
   input  logic                 load_last,
   output logic                 load_ready,
   input  logic                 start,
   input  logic [HACK_PC_W-1:0] pc,
   output logic [DATA_W-1:0]    instr,
   output logic                 cpu_rst,
   output logic                 busy,
   output logic                 halted,
   output logic [1:0]           halt_cause,
   output logic                 load_err,
   output logic                 pc_fault,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [ADDR_W:0]      prog_len
);

   localparam int                CMP_W     = (HACK_PC_W > ADDR_W + 1) ? HACK_PC_W : ADDR_W + 1;
   localparam int                STALL_W   = $clog2(STALL_CYCLES);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t                 state;
   logic [ADDR_W-1:0]      wr_ptr;
   logic [ADDR_W:0]        prog_len_q;
   logic [CNT_W-1:0]       cycle_q;
   logic [STALL_W-1:0]     stall_q;
   logic [HACK_PC_W-1:0]   pc_prev;
   logic                   prev_valid;
   logic                   cpu_rst_q;
   logic                   load_err_q;
   logic                   pc_fault_q;
   logic [1:0]             halt_cause_q;

   logic                   idle_like;
   logic                   accept;
   logic                   in_prog;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_waddr;
   logic [ADDR_W-1:0]      mem_raddr;
   logic [DATA_W-1:0]      mem_rdata;
   logic                   pc_same;
   logic [STALL_W-1:0]     stall_next;
   logic [CNT_W-1:0]       cycle_next;
   logic                   loop_hit;
   logic                   time_hit;

   assign idle_like  = (state == ST_IDLE) || (state == ST_HALT);
   assign load_ready = (state != ST_RUN);
   assign accept     = load_valid && load_ready;

   // A beat accepted from IDLE/HALT always restarts the program at address 0.
   assign mem_we    = accept;
   assign mem_waddr = idle_like ? '0 : wr_ptr;

   // Fetches past the loaded program are gated off before the array.
   assign in_prog   = CMP_W'(pc) < CMP_W'(prog_len_q);
   assign mem_raddr = in_prog ? pc[ADDR_W-1:0] : '0;
   assign instr     = in_prog ? mem_rdata : '0;

   hack_rom_mem #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (load_data),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   // The first RUN cycle has no meaningful previous PC, so it never counts as a stall.
   assign pc_same    = prev_valid && (pc == pc_prev);
   assign stall_next = pc_same ? stall_q + 1'b1 : '0;
   assign cycle_next = cycle_q + 1'b1;
   assign loop_hit   = pc_same && (stall_next == STALL_MAX);
   assign time_hit   = (cycle_next == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         wr_ptr       <= '0;
         prog_len_q   <= '0;
         cycle_q      <= '0;
         stall_q      <= '0;
         pc_prev      <= '0;
         prev_valid   <= 1'b0;
         cpu_rst_q    <= 1'b1;
         load_err_q   <= 1'b0;
         pc_fault_q   <= 1'b0;
         halt_cause_q <= HALT_NONE;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               if (accept) begin
                  wr_ptr       <= ADDR_W'(1);
                  load_err_q   <= 1'b0;
                  halt_cause_q <= HALT_NONE;
                  if (load_last) begin
                     prog_len_q <= (ADDR_W + 1)'(1);
                     state      <= ST_IDLE;
                  end else begin
                     prog_len_q <= '0;
                     state      <= ST_LOAD;
                  end
               end else if (start && (prog_len_q != '0)) begin
                  state        <= ST_RUN;
                  cpu_rst_q    <= 1'b0;
                  cycle_q      <= '0;
                  stall_q      <= '0;
                  prev_valid   <= 1'b0;
                  pc_fault_q   <= 1'b0;
                  halt_cause_q <= HALT_NONE;
               end
            end

            ST_LOAD: begin
               if (accept) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (load_last || (wr_ptr == LAST_ADDR)) begin
                     prog_len_q <= {1'b0, wr_ptr} + 1'b1;
                     state      <= ST_IDLE;
                     if (!load_last) begin
                        load_err_q <= 1'b1;
                     end
                  end
               end
            end

            ST_RUN: begin
               cycle_q    <= cycle_next;
               stall_q    <= stall_next;
               pc_prev    <= pc;
               prev_valid <= 1'b1;
               if (!in_prog) begin
                  pc_fault_q <= 1'b1;
               end
               if (loop_hit) begin
                  state        <= ST_HALT;
                  cpu_rst_q    <= 1'b1;
                  halt_cause_q <= HALT_LOOP;
               end else if (time_hit) begin
                  state        <= ST_HALT;
                  cpu_rst_q    <= 1'b1;
                  halt_cause_q <= HALT_TIMEOUT;
               end
            end

            default: begin
               state     <= ST_IDLE;
               cpu_rst_q <= 1'b1;
            end
         endcase
      end
   end

   assign cpu_rst     = cpu_rst_q;
   assign busy        = (state == ST_RUN);
   assign halted      = (state == ST_HALT);
   assign halt_cause  = halt_cause_q;
   assign load_err    = load_err_q;
   assign pc_fault    = pc_fault_q;
   assign cycle_count = cycle_q;
   assign prog_len    = prog_len_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// tb/tb_hack_rom_loader.sv - directed bench for hack_rom_loader with hand-computed expectations
module tb_hack_rom_loader;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 32;

   logic              clk;
   logic              rst;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_last;
   logic              load_ready;
   logic              start;
   logic [14:0]       pc;
   logic [DATA_W-1:0] instr;
   logic              cpu_rst;
   logic              busy;
   logic              halted;
   logic [1:0]        halt_cause;
   logic              load_err;
   logic              pc_fault;
   logic [CNT_W-1:0]  cycle_count;
   logic [ADDR_W:0]   prog_len;

   int compared   = 0;
   int mismatched = 0;

   hack_rom_loader #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .CNT_W        (CNT_W),
      .MAX_CYCLES   (1000),
      .STALL_CYCLES (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .start       (start),
      .pc          (pc),
      .instr       (instr),
      .cpu_rst     (cpu_rst),
      .busy        (busy),
      .halted      (halted),
      .halt_cause  (halt_cause),
      .load_err    (load_err),
      .pc_fault    (pc_fault),
      .cycle_count (cycle_count),
      .prog_len    (prog_len)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [DATA_W-1:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic run_pc(input logic [14:0] p);
      pc = p;
      tick();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic peek(input string tag, input logic [14:0] p, input logic [DATA_W-1:0] exp);
      pc = p;
      #1;
      check(tag, instr, exp);
   endtask

   initial begin
      rst        = 1'b1;
      load_valid = 1'b0;
      load_data  = '0;
      load_last  = 1'b0;
      start      = 1'b0;
      pc         = '0;
      tick();
      tick();
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_cause", halt_cause, 0);
      check("rst_load_err", load_err, 0);
      check("rst_pc_fault", pc_fault, 0);
      check("rst_cycles", cycle_count, 0);
      check("rst_prog_len", prog_len, 0);
      check("rst_ready", load_ready, 1);
      check("rst_instr", instr, 0);
      rst = 1'b0;

      // start with no program is ignored
      pulse_start();
      check("empty_start_busy", busy, 0);
      check("empty_start_cpu_rst", cpu_rst, 1);

      // self-loop program: @1 ; 0;JMP
      beat(16'h0001, 1'b0);
      check("load1_prog_len", prog_len, 0);
      check("load1_busy", busy, 0);
      beat(16'hEA87, 1'b1);
      check("load2_prog_len", prog_len, 2);
      peek("fetch0", 15'd0, 16'h0001);
      peek("fetch1", 15'd1, 16'hEA87);
      peek("fetch2_beyond", 15'd2, 16'h0000);
      pc = '0;
      pulse_start();
      check("run_cpu_rst", cpu_rst, 0);
      check("run_busy", busy, 1);
      check("run_ready", load_ready, 0);
      check("run_cycles0", cycle_count, 0);
      run_pc(15'd0);
      run_pc(15'd1);
      run_pc(15'd1);
      check("loop_not_yet", busy, 1);
      run_pc(15'd1);
      check("loop_halted", halted, 1);
      check("loop_busy", busy, 0);
      check("loop_cause", halt_cause, 1);
      check("loop_cycles", cycle_count, 4);
      check("loop_cpu_rst", cpu_rst, 1);
      check("loop_ready", load_ready, 1);
      run_pc(15'd1);
      check("halt_frozen", cycle_count, 4);

      // re-run from HALT with an out-of-program fetch
      pc = '0;
      pulse_start();
      check("rerun_busy", busy, 1);
      check("rerun_cause_clr", halt_cause, 0);
      run_pc(15'd0);
      peek("fault_instr", 15'd5, 16'h0000);
      tick();
      check("fault_flag", pc_fault, 1);
      check("fault_still_run", busy, 1);
      run_pc(15'd1);
      run_pc(15'd1);
      run_pc(15'd1);
      check("fault_loop_cause", halt_cause, 1);
      check("fault_loop_cycles", cycle_count, 5);
      check("fault_sticky", pc_fault, 1);

      // load beat and start together in HALT: load wins
      load_valid = 1'b1;
      load_data  = 16'h1234;
      load_last  = 1'b0;
      start      = 1'b1;
      tick();
      load_valid = 1'b0;
      start      = 1'b0;
      check("both_busy", busy, 0);
      check("both_halted", halted, 0);
      check("both_cause_clr", halt_cause, 0);
      check("both_prog_len", prog_len, 0);
      pulse_start();
      check("start_in_load", busy, 0);
      beat(16'h5678, 1'b1);
      check("both_len2", prog_len, 2);
      peek("new_fetch0", 15'd0, 16'h1234);
      peek("new_fetch1", 15'd1, 16'h5678);

      // timeout with toggling PC
      pc = '0;
      pulse_start();
      for (int k = 1; k <= 999; k++) run_pc(15'((k - 1) % 2));
      check("to_busy_999", busy, 1);
      check("to_cycles_999", cycle_count, 999);
      run_pc(15'd1);
      check("to_halted", halted, 1);
      check("to_cause", halt_cause, 2);
      check("to_cycles", cycle_count, 1000);
      check("to_cpu_rst", cpu_rst, 1);

      // loop and timeout land on the same cycle: loop wins
      pc = '0;
      pulse_start();
      check("both_halt_cause_clr", halt_cause, 0);
      for (int k = 1; k <= 997; k++) run_pc(15'((k - 1) % 2));
      run_pc(15'd1);
      run_pc(15'd1);
      check("tie_busy_999", busy, 1);
      run_pc(15'd1);
      check("tie_halted", halted, 1);
      check("tie_cause", halt_cause, 1);
      check("tie_cycles", cycle_count, 1000);

      // overflow: 256 beats without last
      for (int i = 0; i < 256; i++) beat(16'hA500 ^ 16'(i), 1'b0);
      check("ovf_err", load_err, 1);
      check("ovf_len", prog_len, 256);
      check("ovf_idle_halted", halted, 0);
      check("ovf_idle_busy", busy, 0);
      peek("ovf_fetch255", 15'd255, 16'hA5FF);
      peek("ovf_fetch200", 15'd200, 16'hA5C8);
      peek("ovf_fetch256", 15'd256, 16'h0000);
      beat(16'h0001, 1'b0);
      check("ovf_err_clr", load_err, 0);
      beat(16'hEA87, 1'b1);
      check("reload_len", prog_len, 2);
      peek("reload_fetch0", 15'd0, 16'h0001);

      // reset in the middle of a run
      pc = '0;
      pulse_start();
      for (int k = 1; k <= 10; k++) run_pc(15'((k - 1) % 2));
      check("mid_cycles", cycle_count, 10);
      check("mid_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("mrst_cpu_rst", cpu_rst, 1);
      check("mrst_busy", busy, 0);
      check("mrst_len", prog_len, 0);
      check("mrst_cycles", cycle_count, 0);
      tick();
      rst = 1'b0;
      pulse_start();
      check("mrst_start_ignored", busy, 0);
      check("mrst_start_cpu_rst", cpu_rst, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
